// File: rtl/flit_credit_tx.sv
// Credit-based flit injector: queues PE requests in a small FIFO and sends one flit per credit to the router.
// Optional FLIT_TX_SELF_DROP_EN discards requests addressed to this node instead of queueing them.
module flit_credit_tx #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [1:0]                       req_cluster,
  input  logic [1:0]                       req_local,
  input  logic [15:0]                      req_data,
  input  logic [1:0]                       my_cluster,
  input  logic [1:0]                       my_local,
  input  logic                             ci,
  output logic [19:0]                      dataout,
  output logic                             out_valid,
  output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
  output logic                             credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS+1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          accept;
  logic          push;
  logic          pop;

  assign req_ready = (count < DEPTH_C);
  assign accept    = req_valid & req_ready;
  assign pop       = (count != '0) && (credit_cnt != '0);

`ifdef FLIT_TX_SELF_DROP_EN
  // A self-addressed request still handshakes but never occupies a FIFO slot.
  assign push = accept && ({req_cluster, req_local} != {my_cluster, my_local});
`else
  logic unused_addr;
  assign unused_addr = ^{my_cluster, my_local};
  assign push        = accept;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_cluster, req_local, req_data};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) dataout <= mem[rd_ptr];
    end
  end

  // A returned credit beyond the buffer depth means the router and this block disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({pop, ci})
        2'b10: credit_cnt <= credit_cnt - CRED_ONE;
        2'b01: begin
          if (credit_cnt == CRED_MAX) credit_err <= 1'b1;
          else                        credit_cnt <= credit_cnt + CRED_ONE;
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

endmodule
